// File: rtl/calc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : calc_seq_ctrl
// Description : Sequencing controller for the calculator datapath. Accepts one
//               operation at a time (add, sub, mul, div) on two unsigned
//               operands through a start/busy/done handshake and drives the
//               shared out/err display path.
//               Add/sub finish in one execute cycle. Mul is an iterative
//               shift-add and div an iterative restoring divide, each taking
//               `width` iteration cycles.
// Ports       : clk   - rising-edge clock
//               rst   - asynchronous active-high reset
//               start - request, sampled only while idle
//               op    - 0 add, 1 sub, 2 mul, 3 div (latched with start)
//               a, b  - width-bit unsigned operands (latched with start)
//               busy  - high from the accept edge until the result edge
//               done  - one-cycle pulse, result valid from this cycle
//               out   - 2*width-bit result, held until the next result
//               err   - carry/borrow/divide-by-zero flag, held with out
// Config      : CALC_DIV_EN - when defined the restoring divider is built;
//               otherwise op 3 completes like add/sub with out=0, err=1.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_seq_ctrl #(
  parameter int width = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [width-1:0]   a,
  input  logic [width-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*width-1:0] out,
  output logic               err
);

  // Counter must reach `width` itself: values 0..width-1 index the
  // iterations, and `width` marks the result-write cycle.
  localparam int              c_cw   = $clog2(width + 1);
  localparam logic [c_cw-1:0] c_last = c_cw'(width);

  localparam logic [1:0] c_op_add = 2'd0;
  localparam logic [1:0] c_op_sub = 2'd1;
  localparam logic [1:0] c_op_mul = 2'd2;
  localparam logic [1:0] c_op_div = 2'd3;

`ifdef CALC_DIV_EN
  localparam bit c_div_en = 1'b1;
`else
  localparam bit c_div_en = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]         r_op;
  logic [width-1:0]   r_a;
  logic [width-1:0]   r_b;
  logic [c_cw-1:0]    r_cnt;
  logic [2*width-1:0] r_acc;    // product accumulator
  logic [2*width-1:0] r_mcand;  // multiplicand, shifted left each iteration
  logic [width-1:0]   r_shift;  // multiplier (mul) or dividend/quotient (div)
  logic [2*width-1:0] r_out;
  logic               r_err;

  logic [width:0]     w_sum;
  logic [width:0]     w_diff;

  // Single-cycle arithmetic; the extra MSB is the carry (add) or borrow (sub).
  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};

`ifdef CALC_DIV_EN
  logic [width-1:0]   r_rem;
  logic [width:0]     w_trial;
  logic [width:0]     w_trial_sub;
  logic [width-1:0]   w_rem_next;

  // Restoring step: bring down the next dividend bit (MSB of r_shift) and
  // try subtracting the divisor. A clear MSB on the difference means the
  // subtraction fits, which is also the new quotient bit.
  assign w_trial     = {r_rem, r_shift[width-1]};
  assign w_trial_sub = w_trial - {1'b0, r_b};
  assign w_rem_next  = w_trial_sub[width] ? w_trial[width-1:0]
                                          : w_trial_sub[width-1:0];
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if ((op == c_op_mul) || (c_div_en && (op == c_op_div))) begin
            w_next = S_ITER;
          end else begin
            w_next = S_EXEC;
          end
        end
      end
      S_EXEC:  w_next = S_DONE;
      // Divide by zero reaches c_last after one cycle, so it shares this exit.
      S_ITER:  if (r_cnt == c_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign busy = (r_state == S_EXEC) || (r_state == S_ITER);
  assign done = (r_state == S_DONE);
  assign out  = r_out;
  assign err  = r_err;

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_shift <= '0;
      r_out   <= '0;
      r_err   <= 1'b0;
`ifdef CALC_DIV_EN
      r_rem   <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_a     <= a;
            r_b     <= b;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_mcand <= {{width{1'b0}}, a};
`ifdef CALC_DIV_EN
            r_rem   <= '0;
            r_shift <= (op == c_op_div) ? a : b;
`else
            r_shift <= b;
`endif
          end
        end

        S_EXEC: begin
          case (r_op)
            c_op_add: begin
              r_out <= {{(width-1){1'b0}}, w_sum};
              r_err <= w_sum[width];
            end
            c_op_sub: begin
              r_out <= {{(width-1){w_diff[width]}}, w_diff};
              r_err <= w_diff[width];
            end
            // Only op 3 without the divider arrives here.
            default: begin
              r_out <= '0;
              r_err <= 1'b1;
            end
          endcase
        end

        S_ITER: begin
          if (r_cnt != c_last) begin
`ifdef CALC_DIV_EN
            if (r_op == c_op_div) begin
              if (r_b == '0) begin
                // Skip straight to the result-write cycle.
                r_cnt <= c_last;
              end else begin
                r_rem   <= w_rem_next;
                r_shift <= {r_shift[width-2:0], ~w_trial_sub[width]};
                r_cnt   <= r_cnt + c_cw'(1);
              end
            end else
`endif
            begin
              if (r_shift[0]) begin
                r_acc <= r_acc + r_mcand;
              end
              r_mcand <= r_mcand << 1;
              r_shift <= {1'b0, r_shift[width-1:1]};
              r_cnt   <= r_cnt + c_cw'(1);
            end
          end else begin
`ifdef CALC_DIV_EN
            if (r_op == c_op_div) begin
              if (r_b == '0) begin
                r_out <= '0;
                r_err <= 1'b1;
              end else begin
                r_out <= {r_rem, r_shift};
                r_err <= 1'b0;
              end
            end else
`endif
            begin
              r_out <= r_acc;
              r_err <= 1'b0;
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire
